// File: rtl/adc_ddr_emu.sv
// Emulated DDR-output ADC: per-channel words from test patterns or a stream FIFO,
// driven out two bits per lane per word (even bits while outclk is high, odd bits while low).
module adc_ddr_emu #(
    parameter int BITS       = 16,
    parameter int CHANNELS   = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [BITS-1:0]              const_val,
    input  logic [CHANNELS*BITS-1:0]     s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         clr_uflow,
    output logic                         outclk,
    output logic [CHANNELS*BITS/2-1:0]   d,
    output logic                         underrun,
    output logic [31:0]                  word_cnt
);

    localparam int LANES = BITS / 2;
    localparam int W     = CHANNELS * BITS;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] MODE_CONST  = 2'd0;
    localparam logic [1:0] MODE_RAMP   = 2'd1;
    localparam logic [1:0] MODE_PRBS   = 2'd2;
    localparam logic [1:0] MODE_STREAM = 2'd3;

    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic               ph;
    logic [W-1:0]       word_q;
    logic [W-1:0]       last;
    logic [BITS-1:0]    ramp;
    logic [14:0]        lfsr;

    logic [W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;

    logic               fifo_empty;
    logic               fifo_full;
    logic               fetch;
    logic               pop;
    logic               push;
    logic [14:0]        lfsr_next;
    logic [W-1:0]       word_next;
    logic [CHANNELS*LANES-1:0] d_even;
    logic [CHANNELS*LANES-1:0] d_odd;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);

    // A fetch happens on the edge that starts a word: leaving IDLE, or closing the odd half.
    assign fetch = en && ((state == IDLE) || ph);
    assign pop   = fetch && (mode == MODE_STREAM) && !fifo_empty;

    // A pop on this edge frees a slot, so a full FIFO can still accept alongside it.
    assign s_ready = !fifo_full || pop;
    assign push    = s_valid && s_ready;

    assign lfsr_next = {lfsr[13:0], lfsr[14] ^ lfsr[13]};

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        word_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (mode)
                MODE_CONST: word_next[c*BITS +: BITS] = const_val;
                MODE_RAMP:  word_next[c*BITS +: BITS] = ramp + BITS'(c);
                MODE_PRBS:  word_next[c*BITS +: BITS] = BITS'(lfsr_next);
                default:    word_next[c*BITS +: BITS] = fifo_empty ? last[c*BITS +: BITS]
                                                                   : mem[rd_ptr][c*BITS +: BITS];
            endcase
        end
    end

    always_comb begin
        d_even = '0;
        d_odd  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < LANES; k++) begin
                d_even[c*LANES + k] = word_next[c*BITS + 2*k];
                d_odd[c*LANES + k]  = word_q[c*BITS + 2*k + 1];
            end
        end
    end

    // NOTE: FIFO storage has no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph       <= 1'b0;
            outclk   <= 1'b0;
            d        <= '0;
            underrun <= 1'b0;
            word_cnt <= '0;
            word_q   <= '0;
            last     <= '0;
            ramp     <= '0;
            lfsr     <= 15'h7FFF;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            // The later assignment wins, so a fresh underrun beats a simultaneous clear.
            if (clr_uflow) underrun <= 1'b0;
            if (fetch && (mode == MODE_STREAM) && fifo_empty) underrun <= 1'b1;

            if (fetch) begin
                state    <= RUN;
                ph       <= 1'b0;
                outclk   <= 1'b1;
                d        <= d_even;
                word_q   <= word_next;
                word_cnt <= (state == IDLE) ? 32'd1 : word_cnt + 32'd1;
                if (mode == MODE_RAMP) ramp <= ramp + BITS'(1);
                if (mode == MODE_PRBS) lfsr <= lfsr_next;
                if (pop)               last <= mem[rd_ptr];
            end else if ((state == RUN) && !ph) begin
                ph     <= 1'b1;
                outclk <= 1'b0;
                d      <= d_odd;
            end else begin
                state  <= IDLE;
                ph     <= 1'b0;
                outclk <= 1'b0;
                d      <= '0;
            end
        end
    end

endmodule
